// File: rtl/sound_cmd_tx.sv
// Sound-board command transmitter: FIFO of sound numbers replayed as paced SNDNO/SNDWR strobes,
// plus the periodic SNDT IRQ tick. Define SNDCMD_OVFCNT_EN to enable the dropped-write counter.
module sound_cmd_tx #(
  parameter int DEPTH_LOG2 = 3,
  parameter int STB_CYCLES = 4,
  parameter int GAP_CYCLES = 32,
  parameter int TICK_DIV   = 1000
) (
  input  logic                  AXSCL,
  input  logic                  RESET_N,
  input  logic                  CMDWR,
  input  logic [7:0]            CMDDT,
  output logic                  CMDFULL,
  output logic [DEPTH_LOG2:0]   CMDCNT,
  output logic [7:0]            OVFCNT,
  input  logic                  TICKEN,
  output logic [7:0]            SNDNO,
  output logic                  SNDWR,
  output logic                  SNDT
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int TMR_MAX = (GAP_CYCLES > STB_CYCLES) ? GAP_CYCLES : STB_CYCLES;
  localparam int CW      = $clog2(TMR_MAX + 1);
  localparam int TW      = $clog2(TICK_DIV);
  localparam logic [DEPTH_LOG2:0] FULL_CNT  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0]       STB_LD    = CW'(STB_CYCLES - 1);
  localparam logic [CW-1:0]       GAP_LD    = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STRB, GAP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   cnt_nxt;
  logic                  push, pop;
  state_t                state, state_nxt;
  logic [CW-1:0]         tmr, tmr_nxt;
  logic [7:0]            sndno_nxt;
  logic                  sndwr_nxt;
  logic [TW-1:0]         tick_cnt;

  // Full is judged on registered occupancy only, so a same-cycle pop never rescues a write.
  assign push = CMDWR && !CMDFULL;

  always_ff @(posedge AXSCL) begin
    if (push) mem[wr_ptr] <= CMDDT;
  end

  always_comb begin
    cnt_nxt = CMDCNT;
    if (push && !pop)      cnt_nxt = CMDCNT + 1'b1;
    else if (!push && pop) cnt_nxt = CMDCNT - 1'b1;
  end

  always_ff @(posedge AXSCL or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      CMDCNT  <= '0;
      CMDFULL <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      CMDCNT  <= cnt_nxt;
      CMDFULL <= (cnt_nxt == FULL_CNT);
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    sndno_nxt = SNDNO;
    sndwr_nxt = SNDWR;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (CMDCNT != '0) begin
          pop       = 1'b1;
          sndno_nxt = mem[rd_ptr];
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        sndwr_nxt = 1'b1;
        tmr_nxt   = STB_LD;
        state_nxt = STRB;
      end
      STRB: begin
        if (tmr == '0) begin
          sndwr_nxt = 1'b0;
          tmr_nxt   = GAP_LD;
          state_nxt = GAP;
        end else begin
          tmr_nxt = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) state_nxt = IDLE;
        else           tmr_nxt   = tmr - 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge AXSCL or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      tmr   <= '0;
      SNDNO <= 8'h00;
      SNDWR <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      SNDNO <= sndno_nxt;
      SNDWR <= sndwr_nxt;
    end
  end

  // Tick runs free of the TX path; disabling it restarts the full period.
  always_ff @(posedge AXSCL or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_cnt <= '0;
      SNDT     <= 1'b0;
    end else if (!TICKEN) begin
      tick_cnt <= '0;
      SNDT     <= 1'b0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
      SNDT     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
      SNDT     <= 1'b0;
    end
  end

`ifdef SNDCMD_OVFCNT_EN
  logic [7:0] ovf_q;
  always_ff @(posedge AXSCL or negedge RESET_N) begin
    if (!RESET_N)                          ovf_q <= 8'h00;
    else if (CMDWR && CMDFULL && ovf_q != 8'hFF) ovf_q <= ovf_q + 1'b1;
  end
  assign OVFCNT = ovf_q;
`else
  assign OVFCNT = 8'h00;
`endif

endmodule
